// File: rtl/mips_program_loader.sv
// Boot-time byte-stream loader for the MIPS instruction memory.
// Writes N big-endian words from address 0, then releases the core from reset.
module mips_program_loader #(
  parameter int ADDR_WIDTH     = 6,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  // state   | meaning
  // HDR_HI  | waiting for word-count MSB
  // HDR_LO  | waiting for word-count LSB
  // DATA    | assembling words, one imem write per 4 bytes
  // RELEASE | countdown holding cpu_reset after the last write
  // RUN     | core released, stream ignored
  // ERROR   | word count exceeds imem capacity

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    RELEASE,
    RUN,
    ERROR
  } state_t;

  localparam int              RW       = $clog2(RELEASE_CYCLES + 1);
  localparam logic [16:0]     CAPACITY = 17'(2 ** ADDR_WIDTH);
  localparam logic [RW-1:0]   REL_DATA = RW'(RELEASE_CYCLES);
  localparam logic [RW-1:0]   REL_HDR  = RW'(RELEASE_CYCLES - 1);

  state_t          state, next_state;
  logic            accept;
  logic            last_byte;
  logic [15:0]     hdr_n;
  logic [7:0]      count_hi;
  logic [15:0]     words_left;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift_q;
  logic [RW-1:0]   rel_cnt;

  assign byte_ready = ~reset & (state inside {HDR_HI, HDR_LO, DATA});
  assign accept     = byte_valid & byte_ready;
  assign hdr_n      = {count_hi, byte_data};
  assign last_byte  = accept && (state == DATA) && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) state <= HDR_HI;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cpu_reset  = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      HDR_HI:  if (accept) next_state = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_n == 16'd0)                next_state = RELEASE;
          else if ({1'b0, hdr_n} > CAPACITY) next_state = ERROR;
          else                               next_state = DATA;
        end
      end
      DATA:    if (last_byte && words_left == 16'd1) next_state = RELEASE;
      RELEASE: if (rel_cnt == '0) next_state = RUN;
      RUN: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      ERROR:   load_error = 1'b1;
      default: next_state = HDR_HI;
    endcase
    // Reset takes effect on the outputs without waiting for the edge.
    if (reset) begin
      cpu_reset  = 1'b1;
      load_done  = 1'b0;
      load_error = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      count_hi   <= 8'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      shift_q    <= 24'd0;
      rel_cnt    <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) imem_addr <= imem_addr + ADDR_WIDTH'(1);
      case (state)
        HDR_HI: if (accept) count_hi <= byte_data;
        HDR_LO: begin
          if (accept) begin
            words_left <= hdr_n;
            // Empty program: the strobe cycle does not exist, so count one less.
            rel_cnt    <= REL_HDR;
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {shift_q, byte_data};
              words_left <= words_left - 16'd1;
              rel_cnt    <= REL_DATA;
            end else begin
              shift_q <= {shift_q[15:0], byte_data};
            end
          end
        end
        RELEASE: if (rel_cnt != '0) rel_cnt <= rel_cnt - RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: cycle table for the basic load,
// then sequences for gaps, empty/oversize headers, full capacity and mid-load reset.
module tb_mips_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, cpu_reset, load_done, load_error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;

  int n_total = 0;
  int n_pass  = 0;
  int wide_err = 0;
  logic prev_we = 1'b0;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  mips_program_loader #(.ADDR_WIDTH(6), .RELEASE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (imem_we && prev_we) wide_err <= wide_err + 1;
    prev_we <= imem_we;
  end

  typedef struct {
    logic        rst;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic        crst;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vt[20];
  logic [7:0]  t2_bytes[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                8'h8C, 8'h01, 8'h00, 8'h00};
  logic [31:0] t2_words[2]  = '{32'h20080005, 32'h8C010000};
  int          gaps[10]     = '{0, 1, 2, 3, 1, 0, 2, 3, 0, 1};

  function automatic vec_t mk(input logic rst, input logic bv, input logic [7:0] bd,
                              input logic rdy, input logic we, input logic [5:0] addr,
                              input logic [31:0] wd, input logic crst,
                              input logic done, input logic err);
    vec_t v;
    v.rst = rst; v.bv = bv; v.bd = bd; v.rdy = rdy; v.we = we; v.addr = addr;
    v.wd = wd; v.crst = crst; v.done = done; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b ^ 8'h5A, ~b, 8'hC3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    int k;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    got = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      #1;
      if (byte_ready) got = 1'b1;
      @(negedge clk);
      k++;
    end
    byte_valid = 1'b0;
    check("byte accepted", 32'(got), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (!load_done && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_writes(input string name, input int base, input int cnt,
                              input logic [31:0] w0, input logic [31:0] w1);
    check({name, " write count"}, wr_addr.size() - base, cnt);
    for (int j = 0; j < cnt; j++) begin
      if (base + j < wr_addr.size()) begin
        check($sformatf("%s addr[%0d]", name, j), 32'(wr_addr[base + j]), j);
        check($sformatf("%s data[%0d]", name, j), wr_data[base + j], (j == 0) ? w0 : w1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, base;
    logic [31:0] w;

    // Cycle table: T1 reset, T2 back-to-back load, bytes offered in RUN.
    vt[0]  = mk(1, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 0);
    vt[1]  = mk(1, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 0);
    vt[2]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0);
    vt[3]  = mk(0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 0, 0);
    vt[4]  = mk(0, 1, 8'h20, 1, 0, 0, 32'h0,        1, 0, 0);
    vt[5]  = mk(0, 1, 8'h08, 1, 0, 0, 32'h0,        1, 0, 0);
    vt[6]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0);
    vt[7]  = mk(0, 1, 8'h05, 1, 0, 0, 32'h0,        1, 0, 0);
    vt[8]  = mk(0, 1, 8'h8C, 1, 1, 0, 32'h20080005, 1, 0, 0);
    vt[9]  = mk(0, 1, 8'h01, 1, 0, 1, 32'h0,        1, 0, 0);
    vt[10] = mk(0, 1, 8'h00, 1, 0, 1, 32'h0,        1, 0, 0);
    vt[11] = mk(0, 1, 8'h00, 1, 0, 1, 32'h0,        1, 0, 0);
    vt[12] = mk(0, 0, 8'h00, 0, 1, 1, 32'h8C010000, 1, 0, 0);
    vt[13] = mk(0, 0, 8'h00, 0, 0, 2, 32'h0,        1, 0, 0);
    vt[14] = mk(0, 0, 8'h00, 0, 0, 2, 32'h0,        1, 0, 0);
    vt[15] = mk(0, 0, 8'h00, 0, 0, 2, 32'h0,        1, 0, 0);
    vt[16] = mk(0, 0, 8'h00, 0, 0, 2, 32'h0,        1, 0, 0);
    vt[17] = mk(0, 1, 8'hAB, 0, 0, 2, 32'h0,        0, 1, 0);
    vt[18] = mk(0, 1, 8'hCD, 0, 0, 2, 32'h0,        0, 1, 0);
    vt[19] = mk(0, 0, 8'h00, 0, 0, 2, 32'h0,        0, 1, 0);

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      reset      = vt[i].rst;
      byte_valid = vt[i].bv;
      byte_data  = vt[i].bd;
      #1;
      check($sformatf("row%0d byte_ready", i), 32'(byte_ready), 32'(vt[i].rdy));
      check($sformatf("row%0d imem_we", i),    32'(imem_we),    32'(vt[i].we));
      check($sformatf("row%0d imem_addr", i),  32'(imem_addr),  32'(vt[i].addr));
      check($sformatf("row%0d cpu_reset", i),  32'(cpu_reset),  32'(vt[i].crst));
      check($sformatf("row%0d load_done", i),  32'(load_done),  32'(vt[i].done));
      check($sformatf("row%0d load_error", i), 32'(load_error), 32'(vt[i].err));
      if (vt[i].we || vt[i].rst)
        check($sformatf("row%0d imem_wdata", i), imem_wdata, vt[i].wd);
      @(negedge clk);
    end
    byte_valid = 1'b0;

    // T3: same stream with idle gaps.
    do_reset(2);
    base = wr_addr.size();
    for (int i = 0; i < 10; i++) send_byte(t2_bytes[i], gaps[i]);
    wait_done(n);
    check("t3 release latency", n, 5);
    check_writes("t3", base, 2, t2_words[0], t2_words[1]);
    check("t3 strobe width", wide_err, 0);

    // T4: empty program.
    do_reset(2);
    base = wr_addr.size();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done(n);
    check("t4 release latency", n, 4);
    check("t4 write count", wr_addr.size() - base, 0);
    check("t4 cpu_reset", 32'(cpu_reset), 0);

    // T5: oversize headers, including one that would alias under truncation.
    do_reset(2);
    base = wr_addr.size();
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    #1;
    check("t5 0x41 load_error", 32'(load_error), 1);
    check("t5 0x41 byte_ready", 32'(byte_ready), 0);
    check("t5 0x41 cpu_reset", 32'(cpu_reset), 1);
    byte_valid = 1'b1;
    byte_data  = 8'h11;
    repeat (5) @(negedge clk);
    #1;
    byte_valid = 1'b0;
    check("t5 0x41 sticky error", 32'(load_error), 1);
    check("t5 0x41 no done", 32'(load_done), 0);
    check("t5 0x41 write count", wr_addr.size() - base, 0);

    do_reset(2);
    #1;
    check("t5 error cleared by reset", 32'(load_error), 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    #1;
    check("t5 0x100 load_error", 32'(load_error), 1);

    // T5: exactly full memory.
    do_reset(2);
    base = wr_addr.size();
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    for (int wi = 0; wi < 64; wi++) begin
      w = word_of(wi);
      send_byte(w[31:24], 0);
      send_byte(w[23:16], 0);
      send_byte(w[15:8], 0);
      send_byte(w[7:0], 0);
    end
    wait_done(n);
    check("t5 full release latency", n, 5);
    check("t5 full write count", wr_addr.size() - base, 64);
    for (int j = 0; j < 64; j++) begin
      if (base + j < wr_addr.size()) begin
        check($sformatf("t5 full addr[%0d]", j), 32'(wr_addr[base + j]), j);
        check($sformatf("t5 full data[%0d]", j), wr_data[base + j], word_of(j));
      end
    end
    check("t5 full addr wrap", 32'(imem_addr), 0);
    check("t5 full load_error", 32'(load_error), 0);

    // T6: reset part-way through word 0, then the full stream.
    do_reset(2);
    base = wr_addr.size();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    do_reset(1);
    #1;
    check("t6 cpu_reset after reset", 32'(cpu_reset), 1);
    check("t6 addr after reset", 32'(imem_addr), 0);
    for (int i = 0; i < 10; i++) send_byte(t2_bytes[i], 0);
    wait_done(n);
    check("t6 release latency", n, 5);
    check_writes("t6", base, 2, t2_words[0], t2_words[1]);
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_data = 8'(8'hE0 + i);
      @(negedge clk);
      #1;
      check($sformatf("t6 run byte_ready[%0d]", i), 32'(byte_ready), 0);
    end
    byte_valid = 1'b0;
    check("t6 run write count", wr_addr.size() - base, 2);
    check("final strobe width", wide_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
